pe_wght_spad: RTL

Weight scratchpad in each PE. Sits directly downstream of the west weight router: it captures the router's per-beat weight stream (`w_data_spad`/`load_en_spad`) into a local register-file memory. Once a complete filter set is resident it raises a ready flag. It then serves single-cycle-latency random reads to the PE MAC datapath until the PE releases the weights.

---
 rtl/pe_wght_spad.sv | 71 +++++++
 1 files changed

// File: rtl/pe_wght_spad.sv
// pe_wght_spad: per-PE weight scratchpad; captures a router weight stream, flags ready when full, serves 1-cycle reads.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   w_data_i/w_enable_i - incoming weight beat and its strobe (one word per high cycle)
//   wght_ready_o       - high while a complete filter set is resident
//   wr_count_o         - words written since the scratchpad was last emptied
//   rd_en_i/rd_addr_i  - MAC read request and address
//   rd_data_o/rd_valid_o - registered read data (zero when the read was rejected) and its valid
//   release_i          - PE is done with the weights; empty the scratchpad
//   overflow_o         - sticky: a beat arrived while full
module pe_wght_spad #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int kernel_size = 3,
  parameter int NUM_FILTERS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITWIDTH-1:0]      w_data_i,
  input  logic                          w_enable_i,
  output logic                          wght_ready_o,
  output logic [ADDR_BITWIDTH_SPAD:0]   wr_count_o,
  input  logic                          rd_en_i,
  input  logic [ADDR_BITWIDTH_SPAD-1:0] rd_addr_i,
  output logic [DATA_BITWIDTH-1:0]      rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          release_i,
  output logic                          overflow_o
);
  localparam int DEPTH = kernel_size * kernel_size * NUM_FILTERS;
  localparam int PW = ADDR_BITWIDTH_SPAD + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;
  state_t state, state_n;
  logic [PW-1:0] wr_ptr;
  logic [DATA_BITWIDTH-1:0] mem [0:(1<<ADDR_BITWIDTH_SPAD)-1];
  logic we, rd_ok;
  assign we = w_enable_i && state != FULL;
  assign rd_ok = state == FULL && rd_en_i && {1'b0, rd_addr_i} < DEPTH_W;
  assign wght_ready_o = state == FULL;
  assign wr_count_o = wr_ptr;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   state_n = w_enable_i ? (DEPTH == 1 ? FULL : LOADING) : EMPTY;
      LOADING: state_n = (w_enable_i && wr_ptr == DEPTH_W - PW'(1)) ? FULL : LOADING;
      FULL:    state_n = release_i ? EMPTY : FULL;
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      wr_ptr <= '0;
      overflow_o <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      state <= state_n;
      if (state == FULL && release_i) wr_ptr <= '0;
      else if (we) wr_ptr <= wr_ptr + PW'(1);
      if (state == FULL && w_enable_i) overflow_o <= 1'b1;
      rd_valid_o <= rd_ok;
      rd_data_o <= rd_ok ? mem[rd_addr_i] : '0;
    end
  end
  // Contents survive reset and release; only the write pointer is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[ADDR_BITWIDTH_SPAD-1:0]] <= w_data_i;
  end
endmodule
